// File: rtl/unsigned_seq_ctrl.sv
// ============================================================================
// Module      : unsigned_seq_ctrl
// Description : Two-requester sequential unsigned arithmetic unit.
//               - add/sub finish one cycle after acceptance.
//               - mul uses a shift-add loop of WIDTH iterations.
//               - div uses a restoring shift-subtract loop of WIDTH iterations.
//               Only one operation is in flight at a time. The result is held
//               until the consumer accepts it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   UNSIGNED_SEQ_RR_EN  defined   -> round-robin arbitration between requesters
//                       undefined -> fixed priority, req0 wins
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o   request handshake for requester N (0/1)
//   reqN_a_i, reqN_b_i            unsigned operands
//   reqN_op_i                     00 add, 01 sub, 10 mul, 11 div
//   resp_valid_o / resp_ready_i   response handshake
//   resp_id_o                     requester that issued the result
//   resp_lo_o, resp_hi_o          result low / high words
//   resp_err_o                    divide by zero
//   busy_o                        unit is not idle
// ============================================================================
`default_nettype none

module unsigned_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [1:0]       req0_op_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [1:0]       req1_op_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_id_o,
  output logic [WIDTH-1:0] resp_lo_o,
  output logic [WIDTH-1:0] resp_hi_o,
  output logic             resp_err_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Shared working registers:
  //   mul: {acc_hi, acc_lo} is the partial product, multiplier shifts out of acc_lo
  //   div: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
  // Once the loop completes they hold the final result words directly.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand or divisor
  logic             is_div_q, is_div_d;
  logic             id_q, id_d;
  logic             err_q, err_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic grant;

`ifdef UNSIGNED_SEQ_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (req0_valid_i && req1_valid_i) begin
      grant = ~last_grant_q;
    end else begin
      grant = ~req0_valid_i;
    end
  end
`else
  always_comb begin
    grant = ~req0_valid_i;
  end
`endif

  // Readies are gated by rst_n so that both read 0 while reset is held,
  // even though the state register already sits in IDLE.
  assign req0_ready_o = rst_n && (state_q == S_IDLE) && !grant && req0_valid_i;
  assign req1_ready_o = rst_n && (state_q == S_IDLE) &&  grant && req1_valid_i;

  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       sel_op;

  assign accept = req0_ready_o | req1_ready_o;
  assign sel_a  = grant ? req1_a_i  : req0_a_i;
  assign sel_b  = grant ? req1_b_i  : req0_b_i;
  assign sel_op = grant ? req1_op_i : req0_op_i;

  // --------------------------------------------------------------------------
  // Single-cycle datapath (add / sub)
  // --------------------------------------------------------------------------
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_diff;

  assign add_sum  = {1'b0, sel_a} + {1'b0, sel_b};
  // Top bit of the extended difference is the borrow (a < b).
  assign sub_diff = {1'b0, sel_a} - {1'b0, sel_b};

  // --------------------------------------------------------------------------
  // Iterative datapath step
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;

  // Add the multiplicand when the current multiplier LSB is set, then shift the
  // whole {hi, lo} pair right by one, catching the carry in the top bit.
  assign mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;

  // The remainder is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the difference (when taken) fits in WIDTH bits.
  assign div_shift   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge      = (div_shift >= {1'b0, opnd_q});
  assign div_diff    = div_shift[WIDTH-1:0] - opnd_q;
  assign div_rem_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_quo_nxt = {acc_lo_q[WIDTH-2:0], div_ge};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    id_d     = id_q;
    err_d    = err_q;
`ifdef UNSIGNED_SEQ_RR_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d  = grant;
          err_d = 1'b0;
          cnt_d = '0;
`ifdef UNSIGNED_SEQ_RR_EN
          last_grant_d = grant;
`endif
          unique case (sel_op)
            OP_ADD: begin
              acc_lo_d = add_sum[WIDTH-1:0];
              acc_hi_d = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
              state_d  = S_DONE;
            end
            OP_SUB: begin
              acc_lo_d = sub_diff[WIDTH-1:0];
              acc_hi_d = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
              state_d  = S_DONE;
            end
            OP_MUL: begin
              acc_hi_d = '0;
              acc_lo_d = sel_b;
              opnd_d   = sel_a;
              is_div_d = 1'b0;
              state_d  = S_ITER;
            end
            default: begin
              if (sel_b == '0) begin
                acc_lo_d = '1;
                acc_hi_d = sel_a;
                err_d    = 1'b1;
                state_d  = S_DONE;
              end else begin
                acc_hi_d = '0;
                acc_lo_d = sel_a;
                opnd_d   = sel_b;
                is_div_d = 1'b1;
                state_d  = S_ITER;
              end
            end
          endcase
        end
      end

      S_ITER: begin
        if (is_div_q) begin
          acc_hi_d = div_rem_nxt;
          acc_lo_d = div_quo_nxt;
        end else begin
          acc_hi_d = mul_hi_nxt;
          acc_lo_d = mul_lo_nxt;
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      id_q     <= id_d;
      err_q    <= err_d;
    end
  end

`ifdef UNSIGNED_SEQ_RR_EN
  // Starts at 1 so requester 0 wins the first contested grant after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign resp_valid_o = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign resp_id_o    = id_q;
  assign resp_lo_o    = acc_lo_q;
  assign resp_hi_o    = acc_hi_q;
  assign resp_err_o   = err_q;

endmodule

`default_nettype wire

// File: doc/unsigned_seq_ctrl.md
UNSIGNED_SEQ_CTRL -- requirements
Module: unsigned_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  unsigned operands.
REQ-007 req0_op / req1_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer accepts the result.
REQ-010 resp_id  output  1  index of the requester that issued the result.
REQ-011 resp_lo  output  WIDTH  sum, difference, product low half, or quotient.
REQ-012 resp_hi  output  WIDTH  carry/borrow in bit 0 (other bits 0), product high half, or remainder.
REQ-013 resp_err  output  1  divide by zero.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ITER and DONE.
REQ-016 Readiness:
- reqN_ready = (state==IDLE) && grant==N && reqN_valid, combinationally.
- At most one ready is high per cycle.
REQ-017 Acceptance: handshake at edge T captures a, b, op and id, then moves to DONE for add/sub/div-by-zero, or to ITER for mul/div.
REQ-018 Add/sub latency: resp_valid SHALL rise at T+1.
- add: {resp_hi[0], resp_lo} = a+b.
- sub: resp_lo = a-b mod 2^WIDTH; resp_hi[0] = borrow (a<b).
REQ-019 ITER:
- Runs exactly WIDTH cycles with a counter 0..WIDTH-1.
- mul: one shift-add step per cycle; div: one restoring shift-subtract step per cycle.
- resp_valid SHALL rise at T+1+WIDTH.
REQ-020 Results: mul {resp_hi, resp_lo} = a*b (full 2*WIDTH product); div resp_lo = a/b, resp_hi = a%b.
REQ-021 Divide by zero (op=11, b=0):
- Skips ITER; resp_valid at T+1.
- resp_lo = all ones, resp_hi = a, resp_err = 1.
REQ-022 resp_err SHALL be 0 for every other operation.
REQ-023 DONE:
- resp_* stay stable while resp_valid=1 && resp_ready=0.
- On resp_valid && resp_ready, return to IDLE; resp_valid drops the next cycle.
REQ-024 No request is accepted in the cycle the response handshakes; earliest next acceptance is the following cycle in IDLE.
REQ-025 Request inputs are ignored outside IDLE; a requester holding valid waits without loss.
REQ-026 Grant when only one valid: that requester.

Reset
REQ-027 On rst_n low, immediately:
- state=IDLE; busy, resp_valid, resp_err, resp_id, resp_lo, resp_hi, both readies = 0.
- Iteration counter = 0; last_grant = 1.
REQ-028 Reset mid-ITER or mid-DONE SHALL discard the operation with no response produced.

Configuration
REQ-029 Macro UNSIGNED_SEQ_RR_EN, defined: round-robin.
- With both valid, grant the requester not in last_grant.
- last_grant updates on each acceptance; after reset req0 wins first.
REQ-030 UNSIGNED_SEQ_RR_EN undefined: fixed priority.
- req0 wins whenever both are valid; last_grant is absent.

Verification
REQ-031 Add: req0 a=0xFFFFFFFF, b=1, op=00 -> resp at T+1, resp_lo=0, resp_hi=1, id=0, err=0.
REQ-032 Mul: req1 a=0xFFFFFFFF, b=0xFFFFFFFF, op=10 -> resp at T+33, resp_hi=0xFFFFFFFE, resp_lo=0x00000001, id=1.
REQ-033 Div and divide by zero:
- a=100, b=7, op=11 -> resp at T+33, lo=14, hi=2.
- a=5, b=0 -> resp at T+1, lo=0xFFFFFFFF, hi=5, err=1.
REQ-034 Arbitration, both valid continuously with sub ops, resp_ready=1:
- RR build: grants alternate 0,1,0,1.
- Fixed build: all grants go to 0.
REQ-035 Backpressure and reset:
- resp_ready=0 for 5 cycles in DONE -> outputs stable, no new ready; resp_ready=1 -> IDLE next cycle.
- rst_n low at ITER count 10 -> all outputs 0 at once, no resp after release.
